// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifu_fetch_pkg;

    localparam int XLEN      = 32;
    localparam int INSTR_LEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      tag;
    } fq_entry_t;

    // Clears the two low address bits so redirect targets stay word-aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/ifu_fetch_chk.sv
// Simulation-only protocol checks for the fetch front end's memory channel.
module ifu_fetch_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          rsp_valid_i,
    input logic [CW-1:0] outstanding_i,
    input logic [CW-1:0] tag_count_i
);

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid_i |-> (outstanding_i != '0))
        else $error("imem response with no outstanding request");

    a_tags_paired: assert property (@(posedge clk) disable iff (!rst_n)
        tag_count_i == outstanding_i)
        else $error("tag FIFO out of step with outstanding count");

endmodule

// File: rtl/ifu_fetch_fifo_sync.sv
// Synchronous FIFO with clear and occupancy count; DEPTH must be a power of two.
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push_i && (count_q != CNT_FULL);
    assign do_pop_s  = pop_i && (count_q != '0);
    assign dout_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, pointers and count; clear empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch front end: sequential PC generation, request throttling,
// fetch queue with stall hold, and flush redirect with stale-response dropping.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              FQ_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [XLEN-1:0]      imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [INSTR_LEN-1:0] imem_rsp_data,
    output logic [INSTR_LEN-1:0] instr,
    output logic                 instr_valid,
    output logic [XLEN-1:0]      instr_tag,
    input  logic                 pipe_stall,
    input  logic                 pipe_flush,
    input  logic [XLEN-1:0]      redirect_pc
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0]     CAP     = (CW + 1)'(FQ_DEPTH);
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   fq_count_s;
    logic [CW-1:0]   tag_count_s;
    logic [CW:0]     occ_sum_s;
    logic            req_valid_s;
    logic            accept_s;
    logic            rsp_drop_s;
    logic            fq_push_s;
    logic            fq_pop_s;
    logic [XLEN-1:0] tag_head_s;
    fq_entry_t       fq_din_s;
    fq_entry_t       fq_head_s;

    // Request gating, response routing and next-state for PC, counters and FSM.
    always_comb begin
        occ_sum_s   = {1'b0, fq_count_s} + {1'b0, out_q};
        req_valid_s = (state_q == S_RUN) && !pipe_flush && (occ_sum_s < CAP);
        accept_s    = req_valid_s && imem_req_ready;
        rsp_drop_s  = imem_rsp_valid && (pipe_flush || (drop_q != '0));
        fq_push_s   = imem_rsp_valid && !rsp_drop_s;
        fq_pop_s    = instr_valid && !pipe_stall && !pipe_flush;
        fq_din_s    = '{instr: imem_rsp_data, tag: tag_head_s};

        case ({accept_s, imem_rsp_valid})
            2'b10:   out_d = out_q + ONE;
            2'b01:   out_d = out_q - ONE;
            default: out_d = out_q;
        endcase

        // A response arriving with the flush belongs to the old stream, so it is not counted.
        if (pipe_flush) begin
            drop_d = imem_rsp_valid ? (out_q - ONE) : out_q;
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - ONE;
        end else begin
            drop_d = drop_q;
        end

        if (pipe_flush) begin
            pc_d = align_word(redirect_pc);
        end else if (accept_s) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end

        if (pipe_flush) begin
            state_d = (drop_d != '0) ? S_DRAIN : S_RUN;
        end else begin
            case (state_q)
                S_BOOT:  state_d = S_RUN;
                S_RUN:   state_d = S_RUN;
                S_DRAIN: state_d = (drop_d == '0) ? S_RUN : S_DRAIN;
                default: state_d = S_BOOT;
            endcase
        end
    end

    // FSM state, PC and in-flight bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    fifo_sync #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (FQ_DEPTH),
        .CW    (CW)
    ) u_fetch_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (pipe_flush),
        .push_i  (fq_push_s),
        .pop_i   (fq_pop_s),
        .din_i   (fq_din_s),
        .dout_o  (fq_head_s),
        .count_o (fq_count_s)
    );

    // Never cleared: each entry stays matched to its response, dropped or not.
    fifo_sync #(
        .WIDTH (XLEN),
        .DEPTH (FQ_DEPTH),
        .CW    (CW)
    ) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (1'b0),
        .push_i  (accept_s),
        .pop_i   (imem_rsp_valid),
        .din_i   (pc_q),
        .dout_o  (tag_head_s),
        .count_o (tag_count_s)
    );

    ifu_fetch_chk #(
        .CW (CW)
    ) u_chk (
        .clk           (clk),
        .rst_n         (rst_n),
        .rsp_valid_i   (imem_rsp_valid),
        .outstanding_i (out_q),
        .tag_count_i   (tag_count_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign instr          = fq_head_s.instr;
    assign instr_tag      = fq_head_s.tag;
    assign instr_valid    = (fq_count_s != '0);

endmodule
